// File: rtl/sorted_array_streamer.sv
// sorted_array_streamer: snapshots a parallel sorted array on start and streams
// it out one element per valid/ready beat, flagging any descending step.
module sorted_array_streamer #(
  parameter  int unsigned INPUT_ARR_SIZE = 100,
  parameter  int unsigned ELEMENT_SIZE   = 32,
  localparam int unsigned IDX_W          = (INPUT_ARR_SIZE > 1) ? $clog2(INPUT_ARR_SIZE) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [ELEMENT_SIZE-1:0] arr_in [0:INPUT_ARR_SIZE-1],
  output logic [ELEMENT_SIZE-1:0] m_data,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic                    m_last,
  output logic [IDX_W-1:0]        m_index,
  output logic                    busy,
  output logic                    done,
  output logic                    order_err
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(INPUT_ARR_SIZE - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;

  logic [ELEMENT_SIZE-1:0] r_snap [0:INPUT_ARR_SIZE-1];
  logic [ELEMENT_SIZE-1:0] r_data;
  logic [ELEMENT_SIZE-1:0] r_prev;
  logic [IDX_W-1:0]        r_idx;
  logic                    r_valid;
  logic                    r_last;
  logic                    r_busy;
  logic                    r_done;
  logic                    r_err;
  logic                    r_seen;

  logic                    w_hs;
  logic                    w_capture;
  logic [IDX_W-1:0]        w_idx_inc;

  assign w_hs      = r_valid & m_ready;
  assign w_capture = (r_state == IDLE) & start;
  // Saturate at the last index so the snapshot read never leaves the array.
  assign w_idx_inc = r_last ? r_idx : r_idx + IDX_W'(1);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode; start is only honoured from IDLE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nxt = STREAM;
      STREAM:  if (w_hs && r_last) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Snapshot of the input array; contents only matter while streaming.
  always_ff @(posedge clk) begin
    if (w_capture) begin
      r_snap <= arr_in;
    end
  end

  // Registered stream outputs, index walk and running order check.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data  <= '0;
      r_prev  <= '0;
      r_idx   <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_seen  <= 1'b0;
    end else begin
      r_valid <= (w_state_nxt == STREAM);
      r_busy  <= (w_state_nxt != IDLE);
      r_done  <= (w_state_nxt == DONE);
      if (w_capture) begin
        r_idx  <= '0;
        r_data <= arr_in[0];
        r_last <= (INPUT_ARR_SIZE == 1);
        r_err  <= 1'b0;
        r_seen <= 1'b0;
      end else if (w_hs) begin
        if (r_seen && (r_data < r_prev)) begin
          r_err <= 1'b1;
        end
        if (r_last) begin
          r_last <= 1'b0;
        end else begin
          r_idx  <= w_idx_inc;
          r_data <= r_snap[w_idx_inc];
          r_last <= (w_idx_inc == LAST_IDX);
          r_prev <= r_data;
          r_seen <= 1'b1;
        end
      end
    end
  end

  assign m_data    = r_data;
  assign m_valid   = r_valid;
  assign m_last    = r_last;
  assign m_index   = r_idx;
  assign busy      = r_busy;
  assign done      = r_done;
  assign order_err = r_err;

endmodule
